// File: rtl/mem_bus_arb_pkg.sv
// Shared types for the IF/LS memory bus arbiter.
// State encodings, requester ids and the stall counter helper.
package mem_bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_LS = 2'd2
  } arb_state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  localparam int STALL_W = 8;

  function automatic logic [STALL_W-1:0] sat_inc(
    input logic [STALL_W-1:0] v,
    input logic [STALL_W-1:0] max
  );
    return (v >= max) ? max : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_bus_arb_cells.sv
// Flop library cells: dffr (reset flop) and dfflr (reset flop with load).
// Ports: clk, rst_n (async, active-low), [en], d, q; RST is the reset value.
module dffr #(
  parameter int W = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST;
    else        q <= d;
  end

endmodule

module dfflr #(
  parameter int W = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RST;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_bus_arb_stall.sv
// arb_stall_cnt: saturating count of LS grants taken while IF waits.
// Ports: clk, rst_n, inc, clr (wins over inc), sat (count == MAX_STALL).
module arb_stall_cnt
  import mem_bus_arb_pkg::*;
#(
  parameter int MAX_STALL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [STALL_W-1:0] MAX = STALL_W'(MAX_STALL);

  logic [STALL_W-1:0] cnt_q;
  logic [STALL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = sat_inc(cnt_q, MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sat = (cnt_q == MAX);

endmodule

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: one-outstanding arbiter of IF/LS onto a shared memory bus.
// Ports: IF req/rsp, LS req/rsp, m_* bus side; ARB_PERF_EN adds perf_*.
module mem_bus_arb
  import mem_bus_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_STALL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_val,
  output logic          if_req_rdy,
  input  logic [AW-1:0] if_addr,
  output logic          if_rsp_val,
  output logic [DW-1:0] if_rsp_data,
  input  logic          ls_req_val,
  output logic          ls_req_rdy,
  input  logic [AW-1:0] ls_addr,
  input  logic          ls_wen,
  input  logic [DW-1:0] ls_wdata,
  input  logic [DW/8-1:0] ls_wstrb,
  output logic          ls_rsp_val,
  output logic [DW-1:0] ls_rsp_data,
  output logic          m_req_val,
  input  logic          m_req_rdy,
  output logic [AW-1:0] m_addr,
  output logic          m_wen,
  output logic [DW-1:0] m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  input  logic          m_rsp_val,
  input  logic [DW-1:0] m_rsp_data
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]   perf_if_cnt,
  output logic [31:0]   perf_ls_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  logic [1:0] state_q;
  arb_state_t state;
  arb_state_t state_d;
  logic       owner_q;
  logic       owner_d;

  logic idle;
  logic busy;
  logic sat;
  logic sel_ls;
  logic sel_if;
  logic hs;
  logic ls_hs;
  logic if_hs;
  logic rsp_hit;
  logic stall_inc;
  logic stall_clr;

  assign state = arb_state_t'(state_q);
  assign idle  = (state == ARB_IDLE);
  assign busy  = (state == ARB_WAIT_IF) ||
                 (state == ARB_WAIT_LS);

  // LS wins unless IF has already sat out MAX_STALL LS grants.
  assign sel_ls = idle & ls_req_val &
                  ~(if_req_val & sat);
  assign sel_if = idle & if_req_val & ~sel_ls;

  assign m_req_val = sel_ls | sel_if;
  assign hs        = m_req_val & m_req_rdy;
  assign ls_hs     = sel_ls & m_req_rdy;
  assign if_hs     = sel_if & m_req_rdy;

  assign ls_req_rdy = ls_hs;
  assign if_req_rdy = if_hs;

  assign m_addr  = sel_ls ? ls_addr : if_addr;
  assign m_wen   = sel_ls & ls_wen;
  assign m_wdata = sel_ls ? ls_wdata : '0;
  assign m_wstrb = sel_ls ? ls_wstrb : '0;

  // A response in IDLE has no owner and is dropped.
  assign rsp_hit    = busy & m_rsp_val;
  assign if_rsp_val = rsp_hit & (owner_q == REQ_IF);
  assign ls_rsp_val = rsp_hit & (owner_q == REQ_LS);
  assign if_rsp_data = m_rsp_data;
  assign ls_rsp_data = m_rsp_data;

  always_comb begin
    state_d = state;
    unique case (1'b1)
      idle: begin
        if (hs)
          state_d = sel_ls ? ARB_WAIT_LS
                           : ARB_WAIT_IF;
      end
      busy: begin
        if (m_rsp_val) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign owner_d = sel_ls ? REQ_LS : REQ_IF;

  dffr #(
    .W   (2),
    .RST (2'(ARB_IDLE))
  ) u_state (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (state_d),
    .q     (state_q)
  );

  dfflr #(
    .W   (1),
    .RST (REQ_IF)
  ) u_owner (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hs),
    .d     (owner_d),
    .q     (owner_q)
  );

  assign stall_inc = ls_hs & if_req_val;
  assign stall_clr = if_hs | (idle & ~if_req_val);

  arb_stall_cnt #(
    .MAX_STALL (MAX_STALL)
  ) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (stall_clr),
    .sat   (sat)
  );

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_cnt    <= '0;
      perf_ls_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (if_hs)
        perf_if_cnt <= perf_if_cnt + 32'd1;
      if (ls_hs)
        perf_ls_cnt <= perf_ls_cnt + 32'd1;
      if (if_req_val & ~if_hs)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arb.sv
// Scoreboard bench for mem_bus_arb: directed IF/LS traffic,
// expected grants/requests/responses queued and popped by a monitor.
module tb_mem_bus_arb;
  import mem_bus_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req_val;
  logic          if_req_rdy;
  logic [AW-1:0] if_addr;
  logic          if_rsp_val;
  logic [DW-1:0] if_rsp_data;
  logic          ls_req_val;
  logic          ls_req_rdy;
  logic [AW-1:0] ls_addr;
  logic          ls_wen;
  logic [DW-1:0] ls_wdata;
  logic [3:0]    ls_wstrb;
  logic          ls_rsp_val;
  logic [DW-1:0] ls_rsp_data;
  logic          m_req_val;
  logic          m_req_rdy;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_rsp_val;
  logic [DW-1:0] m_rsp_data;
`ifdef ARB_PERF_EN
  logic [31:0]   perf_if_cnt;
  logic [31:0]   perf_ls_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  mem_bus_arb #(
    .AW (AW), .DW (DW), .MAX_STALL (MS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_val  (if_req_val),
    .if_req_rdy  (if_req_rdy),
    .if_addr     (if_addr),
    .if_rsp_val  (if_rsp_val),
    .if_rsp_data (if_rsp_data),
    .ls_req_val  (ls_req_val),
    .ls_req_rdy  (ls_req_rdy),
    .ls_addr     (ls_addr),
    .ls_wen      (ls_wen),
    .ls_wdata    (ls_wdata),
    .ls_wstrb    (ls_wstrb),
    .ls_rsp_val  (ls_rsp_val),
    .ls_rsp_data (ls_rsp_data),
    .m_req_val   (m_req_val),
    .m_req_rdy   (m_req_rdy),
    .m_addr      (m_addr),
    .m_wen       (m_wen),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_rsp_val   (m_rsp_val),
    .m_rsp_data  (m_rsp_data)
`ifdef ARB_PERF_EN
    ,
    .perf_if_cnt    (perf_if_cnt),
    .perf_ls_cnt    (perf_ls_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not expected", name);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } ls_req_t;

  ls_req_t     ls_stim[$];
  logic [31:0] if_stim[$];
  ls_req_t     exp_ls_req[$];
  logic [31:0] exp_if_req[$];
  logic [31:0] exp_ls_rsp[$];
  logic [31:0] exp_if_rsp[$];
  logic        exp_gnt[$];

  int  lat     = 1;
  bit  mute    = 0;
  bit  inj     = 0;
  bit  cnt_chk = 0;

  function automatic logic [31:0] bus_data(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  task automatic push_if(input logic [31:0] a);
    if_stim.push_back(a);
    exp_if_req.push_back(a);
    exp_if_rsp.push_back(bus_data(a));
  endtask

  task automatic push_ls(input logic [31:0] a,
                         input logic w,
                         input logic [31:0] d,
                         input logic [3:0] s);
    ls_req_t r;
    r.addr = a; r.wen = w; r.wdata = d; r.wstrb = s;
    ls_stim.push_back(r);
    exp_ls_req.push_back(r);
    exp_ls_rsp.push_back(bus_data(a));
  endtask

  task automatic clear_all();
    ls_stim.delete();
    if_stim.delete();
    exp_ls_req.delete();
    exp_if_req.delete();
    exp_ls_rsp.delete();
    exp_if_rsp.delete();
    exp_gnt.delete();
  endtask

  // Requesters hold each request until it is accepted.
  initial begin
    bit ifh, lsh;
    if_req_val = 0; if_addr = '0;
    ls_req_val = 0; ls_addr = '0;
    ls_wen = 0; ls_wdata = '0; ls_wstrb = '0;
    forever begin
      @(negedge clk);
      ifh = if_req_val & if_req_rdy;
      lsh = ls_req_val & ls_req_rdy;
      @(posedge clk);
      #1;
      if (ifh && if_stim.size() > 0)
        void'(if_stim.pop_front());
      if (lsh && ls_stim.size() > 0)
        void'(ls_stim.pop_front());
      if (if_stim.size() > 0) begin
        if_req_val = 1; if_addr = if_stim[0];
      end else begin
        if_req_val = 0; if_addr = '0;
      end
      if (ls_stim.size() > 0) begin
        ls_req_val = 1;
        ls_addr  = ls_stim[0].addr;
        ls_wen   = ls_stim[0].wen;
        ls_wdata = ls_stim[0].wdata;
        ls_wstrb = ls_stim[0].wstrb;
      end else begin
        ls_req_val = 0; ls_addr = '0;
        ls_wen = 0; ls_wdata = '0; ls_wstrb = '0;
      end
    end
  end

  // Bus model: answers each accepted request after lat cycles.
  initial begin
    bit          bh, pend;
    int          dly;
    logic [31:0] ba, paddr;
    pend = 0; dly = 0; paddr = '0;
    m_rsp_val = 0; m_rsp_data = '0;
    forever begin
      @(negedge clk);
      bh = m_req_val & m_req_rdy & rst_n;
      ba = m_addr;
      @(posedge clk);
      #1;
      m_rsp_val = 0; m_rsp_data = '0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (bh && !mute) begin
          pend = 1; dly = lat; paddr = ba;
        end
        if (inj) begin
          m_rsp_val = 1; m_rsp_data = 32'hBAD0_0001;
          inj = 0;
        end
        if (pend) begin
          if (dly <= 1) begin
            m_rsp_val = 1;
            m_rsp_data = bus_data(paddr);
            pend = 0;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT shows a grant/response.
  initial begin
    bit          prev_if;
    int          if_hs_cyc, ls_hs_cyc;
    logic        g;
    ls_req_t     r;
    logic [31:0] a;
    prev_if = 0; if_hs_cyc = 0; ls_hs_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_if = 0;
        continue;
      end
      if (cnt_chk && prev_if)
        check("stall_clr", 64'(dut.u_stall.cnt_q), 0);
      prev_if = if_req_rdy;
      if (if_req_rdy || ls_req_rdy) begin
        check("one_rdy", 64'(if_req_rdy & ls_req_rdy), 0);
        if (exp_gnt.size() == 0) begin
          fail("gnt_unexp");
        end else begin
          g = exp_gnt.pop_front();
          check("gnt_side", 64'(ls_req_rdy), 64'(g));
        end
      end
      if (ls_req_rdy) begin
        ls_hs_cyc = cyc;
        if (exp_ls_req.size() > 0) begin
          r = exp_ls_req.pop_front();
          check("ls_m_addr", m_addr, r.addr);
          check("ls_m_wen", 64'(m_wen), 64'(r.wen));
          check("ls_m_wdata", m_wdata, r.wdata);
          check("ls_m_wstrb", 64'(m_wstrb), 64'(r.wstrb));
        end
      end
      if (if_req_rdy) begin
        if_hs_cyc = cyc;
        if (exp_if_req.size() > 0) begin
          a = exp_if_req.pop_front();
          check("if_m_addr", m_addr, a);
          check("if_m_wen", 64'(m_wen), 0);
          check("if_m_wstrb", 64'(m_wstrb), 0);
        end
        if (cnt_chk)
          check("stall_at_if",
                64'(dut.u_stall.cnt_q), MS);
      end
      if (if_rsp_val) begin
        if (exp_if_rsp.size() == 0) begin
          fail("if_rsp_unexp");
        end else begin
          check("if_rsp_data", if_rsp_data,
                exp_if_rsp.pop_front());
          check("if_rsp_lat", cyc - if_hs_cyc, lat);
        end
      end
      if (ls_rsp_val) begin
        if (exp_ls_rsp.size() == 0) begin
          fail("ls_rsp_unexp");
        end else begin
          check("ls_rsp_data", ls_rsp_data,
                exp_ls_rsp.pop_front());
          check("ls_rsp_lat", cyc - ls_hs_cyc, lat);
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((exp_if_rsp.size() + exp_ls_rsp.size() +
            exp_gnt.size() + if_stim.size() +
            ls_stim.size()) != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (k >= 300) fail({name, "_timeout"});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    int k;
    rst_n = 0;
    m_req_rdy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_rdy", 64'(if_req_rdy), 0);
    check("rst_ls_rdy", 64'(ls_req_rdy), 0);
    check("rst_m_val", 64'(m_req_val), 0);
    check("rst_if_rsp", 64'(if_rsp_val), 0);
    check("rst_ls_rsp", 64'(ls_rsp_val), 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_state", 64'(dut.state), 64'(ARB_IDLE));
    check("rst_stall", 64'(dut.u_stall.cnt_q), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    m_req_rdy = 1;

    // IF alone, two-cycle bus latency
    lat = 2;
    exp_gnt.push_back(REQ_IF);
    push_if(32'h8000_0000);
    wait_done("t1");

    // simultaneous: LS write wins first
    lat = 1;
    exp_gnt.push_back(REQ_LS);
    exp_gnt.push_back(REQ_IF);
    push_ls(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    push_if(32'h8000_0040);
    wait_done("t2");

    // backpressure holds LS request steady in IDLE
    m_req_rdy = 0;
    exp_gnt.push_back(REQ_LS);
    push_ls(32'h8000_2000, 1'b0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_m_val", 64'(m_req_val), 1);
      check("bp_m_addr", m_addr, 32'h8000_2000);
      check("bp_ls_rdy", 64'(ls_req_rdy), 0);
      check("bp_if_rdy", 64'(if_req_rdy), 0);
      check("bp_state", 64'(dut.state), 64'(ARB_IDLE));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    m_req_rdy = 1;
    wait_done("t4");

    // reset while waiting on an LS response
    mute = 1;
    exp_gnt.push_back(REQ_LS);
    push_ls(32'h8000_3000, 1'b0, 32'h0, 4'h0);
    k = 0;
    @(negedge clk);
    while (dut.state != ARB_WAIT_LS && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) fail("t5_no_wait_ls");
    do_reset();
    mute = 0;
    @(negedge clk);
    inj = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_rsp",
            64'(if_rsp_val | ls_rsp_val), 0);
      check("rst_mid_state",
            64'(dut.state), 64'(ARB_IDLE));
    end

    // starvation bound, both sides held valid
    do_reset();
    lat = 1;
    cnt_chk = 1;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < MS; j++)
        exp_gnt.push_back(REQ_LS);
      exp_gnt.push_back(REQ_IF);
    end
    for (int i = 0; i < 2; i++)
      push_if(32'h8000_0100 + 32'(i * 4));
    for (int i = 0; i < 8; i++)
      push_ls(32'h8000_4000 + 32'(i * 4),
              i[0], 32'h1111_0000 + 32'(i),
              4'(i + 1));
    wait_done("t3");
    cnt_chk = 0;

`ifdef ARB_PERF_EN
    check("perf_sum",
          64'(perf_if_cnt + perf_ls_cnt), 10);
    check("perf_if", 64'(perf_if_cnt), 2);
    check("perf_ls", 64'(perf_ls_cnt), 8);
    check("perf_stall_nz",
          64'(perf_stall_cnt != 0), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
